// File: rtl/psc_batch_feeder.sv
// psc_batch_feeder: gathers 4*LANES words into one batch image, starts the converter array, waits for finish.
// Optional feature: define PSC_FEED_PINGPONG_EN for double-buffered filling while the array is busy.
`default_nettype none

module psc_batch_feeder #(
    parameter int WORD_LEN = 16,
    parameter int LANES    = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [1:0]                   cfg_mode,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WORD_LEN-1:0]          in_data,
    output logic [1:0]                   psc_mode,
    output logic                         psc_start,
    input  logic                         psc_finish,
    output logic [4*WORD_LEN*LANES-1:0]  psc_parallel_out,
    output logic                         busy,
    output logic                         batch_done,
    output logic [15:0]                  batch_count
);

    localparam int NWORDS = 4 * LANES;
    localparam int TOTAL  = NWORDS * WORD_LEN;
    localparam int PTR_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NWORDS - 1);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t            state, next_state;
    logic [PTR_W-1:0]  wr_ptr;
    logic              alive;
    logic [1:0]        mode_q;
    logic              done_q;
    logic [15:0]       count_q;

    logic              xfer;
    logic              last_xfer;
    logic              launch;
    logic              take_finish;

    assign xfer        = in_valid & in_ready;
    assign last_xfer   = xfer & (wr_ptr == LAST_PTR);
    assign take_finish = (state == WAIT) & psc_finish;

`ifdef PSC_FEED_PINGPONG_EN
    // Words always go to the inactive bank; the active bank is the one the array sees.
    logic [TOTAL-1:0]  bank [2];
    logic              act;
    logic              fill_full;
    logic              fill_complete;

    assign fill_complete = fill_full | last_xfer;
    assign launch        = ((state == FILL) & last_xfer) |
                           ((state == WAIT) & psc_finish & fill_complete);
    assign in_ready      = alive & ~fill_full;
    assign psc_parallel_out = bank[act];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bank[0]   <= '0;
            bank[1]   <= '0;
            act       <= 1'b0;
            fill_full <= 1'b0;
        end else begin
            if (xfer)
                bank[~act][int'(wr_ptr)*WORD_LEN +: WORD_LEN] <= in_data;
            if (launch)
                act <= ~act;
            if (launch)
                fill_full <= 1'b0;
            else if (last_xfer)
                fill_full <= 1'b1;
        end
    end
`else
    logic [TOTAL-1:0]  buf_q;

    assign launch           = (state == FILL) & last_xfer;
    assign in_ready         = alive & (state == FILL);
    assign psc_parallel_out = buf_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            buf_q <= '0;
        else if (xfer)
            buf_q[int'(wr_ptr)*WORD_LEN +: WORD_LEN] <= in_data;
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= FILL;
            wr_ptr  <= '0;
            alive   <= 1'b0;
            mode_q  <= 2'd0;
            done_q  <= 1'b0;
            count_q <= 16'd0;
        end else begin
            state  <= next_state;
            alive  <= 1'b1;
            done_q <= take_finish;
            if (xfer)
                wr_ptr <= last_xfer ? '0 : wr_ptr + 1'b1;
            if (launch)
                mode_q <= cfg_mode;
            if (take_finish)
                count_q <= count_q + 16'd1;
        end
    end

    // Finish is only looked at in WAIT, so a level held through START counts once.
    always_comb begin
        next_state = state;
        case (state)
            FILL:    if (launch) next_state = START;
            START:   next_state = WAIT;
            WAIT:    if (psc_finish) next_state = launch ? START : FILL;
            default: next_state = FILL;
        endcase
    end

    assign psc_start   = (state == START);
    assign busy        = (state == START) || (state == WAIT);
    assign psc_mode    = mode_q;
    assign batch_done  = done_q;
    assign batch_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_psc_batch_feeder.sv
// Self-checking bench for psc_batch_feeder: scoreboard of accepted words checked against each started batch.
`default_nettype none

module tb_psc_batch_feeder;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   cfg_mode;
    logic         in_valid;
    logic         in_ready;
    logic [15:0]  in_data;
    logic [1:0]   psc_mode;
    logic         psc_start;
    logic         psc_finish;
    logic [255:0] psc_parallel_out;
    logic         busy;
    logic         batch_done;
    logic [15:0]  batch_count;

    int           tests_run    = 0;
    int           tests_failed = 0;
    logic [15:0]  sb_q [$];
    logic [255:0] exp_image;

    psc_batch_feeder #(.WORD_LEN(16), .LANES(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .cfg_mode         (cfg_mode),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_data          (in_data),
        .psc_mode         (psc_mode),
        .psc_start        (psc_start),
        .psc_finish       (psc_finish),
        .psc_parallel_out (psc_parallel_out),
        .busy             (busy),
        .batch_done       (batch_done),
        .batch_count      (batch_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers 16 words base..base+15; a word is pushed to the scoreboard when the handshake occurs.
    task automatic feed_batch(input logic [15:0] base, input bit gaps);
        for (int i = 0; i < 16; i++) begin
            if (gaps) begin
                int idle = $urandom_range(0, 2);
                for (int g = 0; g < idle; g++) begin
                    in_valid = 1'b0;
                    in_data  = 16'($urandom);
                    tick();
                end
            end
            in_valid = 1'b1;
            in_data  = base + 16'(i);
            for (int w = 0; w < 200 && !in_ready; w++) tick();
            if (!in_ready) begin
                tests_run++; tests_failed++;
                $display("FAIL feed_timeout word %0d: in_ready=%b required 1", i, in_ready);
            end
            sb_q.push_back(in_data);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; cfg_mode = 2'd0; in_valid = 1'b0; in_data = '0; psc_finish = 1'b0;
        tick(); tick();
        tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        tests_run++; if (psc_start !== 1'b0) begin tests_failed++; $display("FAIL reset_start: got %b want 0", psc_start); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests_run++; if (batch_done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b want 0", batch_done); end
        tests_run++; if (batch_count !== 16'd0) begin tests_failed++; $display("FAIL reset_count: got %0d want 0", batch_count); end
        tests_run++; if (psc_mode !== 2'd0) begin tests_failed++; $display("FAIL reset_mode: got %0d want 0", psc_mode); end
        tests_run++; if (psc_parallel_out !== 256'd0) begin tests_failed++; $display("FAIL reset_image: got %h want 0", psc_parallel_out); end
        reset = 1'b1;
        tick();
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
        sb_q.delete();
    endtask

    task automatic test_fill_basic();
        cfg_mode = 2'd2;
        feed_batch(16'h0000, 1'b0);
        cfg_mode = 2'd0;
        for (int i = 0; i < 16; i++) exp_image[i*16 +: 16] = (sb_q.size() > 0) ? sb_q.pop_front() : 16'hxxxx;
        tests_run++; if (psc_start !== 1'b1) begin tests_failed++; $display("FAIL basic_start_latency: got %b want 1", psc_start); end
        tests_run++; if (psc_mode !== 2'd2) begin tests_failed++; $display("FAIL basic_mode: got %0d want 2", psc_mode); end
        tests_run++; if (psc_parallel_out[15:0] !== 16'h0000) begin tests_failed++; $display("FAIL basic_word0: got %h want 0000", psc_parallel_out[15:0]); end
        tests_run++; if (psc_parallel_out[255:240] !== 16'h000F) begin tests_failed++; $display("FAIL basic_word15: got %h want 000f", psc_parallel_out[255:240]); end
        tests_run++; if (psc_parallel_out !== exp_image) begin tests_failed++; $display("FAIL basic_image: got %h want %h", psc_parallel_out, exp_image); end
        tick();
        tests_run++; if (psc_start !== 1'b0 || busy !== 1'b1) begin tests_failed++; $display("FAIL basic_start_pulse: start=%b busy=%b want 0/1", psc_start, busy); end
    endtask

    task automatic test_wait_hold();
        int bad_img = 0, bad_start = 0, bad_rdy = 0;
        for (int c = 0; c < 50; c++) begin
            if (psc_parallel_out !== exp_image) bad_img++;
            if (psc_start !== 1'b0 || batch_done !== 1'b0) bad_start++;
`ifdef PSC_FEED_PINGPONG_EN
            if (in_ready !== 1'b1) bad_rdy++;
`else
            if (in_ready !== 1'b0) bad_rdy++;
`endif
            tick();
        end
        tests_run++; if (bad_img != 0) begin tests_failed++; $display("FAIL hold_image: %0d changed cycles, want 0", bad_img); end
        tests_run++; if (bad_start != 0) begin tests_failed++; $display("FAIL hold_no_restart: %0d bad cycles, want 0", bad_start); end
        tests_run++; if (bad_rdy != 0) begin tests_failed++; $display("FAIL hold_in_ready: %0d bad cycles, want 0", bad_rdy); end
        psc_finish = 1'b1;
        tick();
        psc_finish = 1'b0;
        tests_run++; if (batch_done !== 1'b1) begin tests_failed++; $display("FAIL finish_done: got %b want 1", batch_done); end
        tests_run++; if (batch_count !== 16'd1) begin tests_failed++; $display("FAIL finish_count: got %0d want 1", batch_count); end
        tests_run++; if (in_ready !== 1'b1 || busy !== 1'b0) begin tests_failed++; $display("FAIL finish_ready: ready=%b busy=%b want 1/0", in_ready, busy); end
        tick();
        tests_run++; if (batch_done !== 1'b0) begin tests_failed++; $display("FAIL finish_pulse: got %b want 0", batch_done); end
    endtask

    // Random valid gaps and random finish; backpressure comes from the DUT's own in_ready.
    task automatic test_random_stream();
        logic [15:0] next_word = 16'h4000;
        int starts = 0;
        for (int c = 0; c < 4000 && starts < 3; c++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            in_data    = in_valid ? next_word : 16'($urandom);
            psc_finish = ($urandom_range(0, 3) == 0);
            cfg_mode   = 2'($urandom);
            if (in_valid && in_ready) begin
                sb_q.push_back(next_word);
                next_word++;
            end
            tick();
            if (psc_start) begin
                for (int i = 0; i < 16; i++) exp_image[i*16 +: 16] = (sb_q.size() > 0) ? sb_q.pop_front() : 16'hxxxx;
                starts++;
                tests_run++; if (psc_parallel_out !== exp_image) begin tests_failed++; $display("FAIL stream_image batch %0d: got %h want %h", starts, psc_parallel_out, exp_image); end
            end
        end
        tests_run++; if (starts != 3) begin tests_failed++; $display("FAIL stream_progress: got %0d starts want 3", starts); end
        in_valid = 1'b0; psc_finish = 1'b0;
    endtask

    task automatic test_reset_midbatch();
        reset = 1'b0; tick(); reset = 1'b1; tick();
        sb_q.delete();
        cfg_mode = 2'd1;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; in_data = 16'hA000 + 16'(i);
            tick();
        end
        in_valid = 1'b0;
        reset = 1'b0;
        #1;
        tests_run++; if (busy !== 1'b0 || psc_start !== 1'b0 || in_ready !== 1'b0) begin tests_failed++; $display("FAIL midfill_reset: busy=%b start=%b ready=%b want 0/0/0", busy, psc_start, in_ready); end
        tick(); reset = 1'b1; tick();
        feed_batch(16'h0100, 1'b1);
        for (int i = 0; i < 16; i++) exp_image[i*16 +: 16] = (sb_q.size() > 0) ? sb_q.pop_front() : 16'hxxxx;
        tests_run++; if (psc_start !== 1'b1) begin tests_failed++; $display("FAIL refill_start: got %b want 1", psc_start); end
        tests_run++; if (psc_parallel_out[15:0] !== 16'h0100) begin tests_failed++; $display("FAIL refill_word0: got %h want 0100", psc_parallel_out[15:0]); end
        tests_run++; if (psc_parallel_out !== exp_image) begin tests_failed++; $display("FAIL refill_image: got %h want %h", psc_parallel_out, exp_image); end
        tests_run++; if (batch_count !== 16'd0 || psc_mode !== 2'd1) begin tests_failed++; $display("FAIL refill_count_mode: count=%0d mode=%0d want 0/1", batch_count, psc_mode); end
        tick();
        reset = 1'b0;
        #1;
        tests_run++; if (busy !== 1'b0 || psc_start !== 1'b0 || batch_done !== 1'b0) begin tests_failed++; $display("FAIL midwait_reset: busy=%b start=%b done=%b want 0/0/0", busy, psc_start, batch_done); end
        tests_run++; if (psc_parallel_out !== 256'd0) begin tests_failed++; $display("FAIL midwait_image: got %h want 0", psc_parallel_out); end
        tick(); reset = 1'b1; tick();
        sb_q.delete();
    endtask

    task automatic test_finish_stuck();
        int dones = 0;
        psc_finish = 1'b1;
        feed_batch(16'h0200, 1'b0);
        sb_q.delete();
        tests_run++; if (psc_start !== 1'b1) begin tests_failed++; $display("FAIL stuck_start: got %b want 1", psc_start); end
        tick();
        tests_run++; if (batch_done !== 1'b0 || busy !== 1'b1) begin tests_failed++; $display("FAIL stuck_ignored_in_start: done=%b busy=%b want 0/1", batch_done, busy); end
        for (int c = 0; c < 20; c++) begin
            tick();
            if (batch_done === 1'b1) dones++;
        end
        tests_run++; if (dones != 1) begin tests_failed++; $display("FAIL stuck_done_count: got %0d want 1", dones); end
        tests_run++; if (batch_count !== 16'd1) begin tests_failed++; $display("FAIL stuck_count: got %0d want 1", batch_count); end
        psc_finish = 1'b0;
        tick();
    endtask

`ifdef PSC_FEED_PINGPONG_EN
    task automatic test_pingpong();
        int bad_rdy = 0;
        reset = 1'b0; tick(); reset = 1'b1; tick();
        sb_q.delete();
        cfg_mode = 2'd3;
        for (int i = 0; i < 32; i++) begin
            in_valid = 1'b1; in_data = 16'hC000 + 16'(i);
            if (in_ready !== 1'b1) bad_rdy++;
            sb_q.push_back(in_data);
            tick();
            if (psc_start) begin
                for (int k = 0; k < 16; k++) exp_image[k*16 +: 16] = (sb_q.size() > 0) ? sb_q.pop_front() : 16'hxxxx;
                tests_run++; if (psc_parallel_out !== exp_image) begin tests_failed++; $display("FAIL pp_first_image: got %h want %h", psc_parallel_out, exp_image); end
            end
        end
        in_valid = 1'b0;
        tests_run++; if (bad_rdy != 0) begin tests_failed++; $display("FAIL pp_ready_in_wait: %0d stalled words want 0", bad_rdy); end
        tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL pp_full_ready: got %b want 0", in_ready); end
        psc_finish = 1'b1;
        tick();
        psc_finish = 1'b0;
        for (int k = 0; k < 16; k++) exp_image[k*16 +: 16] = (sb_q.size() > 0) ? sb_q.pop_front() : 16'hxxxx;
        tests_run++; if (batch_done !== 1'b1 || psc_start !== 1'b1) begin tests_failed++; $display("FAIL pp_overlap: done=%b start=%b want 1/1", batch_done, psc_start); end
        tests_run++; if (psc_parallel_out !== exp_image) begin tests_failed++; $display("FAIL pp_second_image: got %h want %h", psc_parallel_out, exp_image); end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_fill_basic();
        test_wait_hold();
        test_random_stream();
        test_reset_midbatch();
        test_finish_stuck();
`ifdef PSC_FEED_PINGPONG_EN
        test_pingpong();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
